// File: rtl/plant_sensor_frontend_if.sv
// Actuator handshake between the line-control FSM (plus the servo end-position
// switch) and the plant sensor front end.
//   servo, conveyor : actuator commands from the control FSM
//   servo_ack       : servo end-position switch, synchronous
//   done, error     : servo move complete / timed out (levels)
//   ready           : conveyor settled after a servo cycle
// master = controller/plant side, slave = front-end responder side.
interface plant_sensor_frontend_if;
  logic servo;
  logic conveyor;
  logic servo_ack;
  logic done;
  logic error;
  logic ready;

  modport master (
    output servo,
    output conveyor,
    output servo_ack,
    input  done,
    input  error,
    input  ready
  );

  modport slave (
    input  servo,
    input  conveyor,
    input  servo_ack,
    output done,
    output error,
    output ready
  );
endinterface

// File: rtl/plant_sensor_frontend.sv
// Plant sensor front end: conditions raw sensor pins and actuator feedback into
// clean status/event levels for the line-control FSM.
// Optional build macro: ESTOP_LATCH_EN makes emergency sticky until fault_clear
// is pulsed while the debounced estop is released.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   metal_raw       : raw metal sensor (asynchronous)
//   estop_raw       : raw emergency button (asynchronous)
//   temp_sample/_valid    : temperature ADC result and strobe
//   current_sample/_valid : motor current ADC result and strobe
//   act             : actuator handshake (servo/conveyor in, done/error/ready out)
//   fault_clear     : clears sticky faults
//   metal_detected, emergency, high_temp, temp_normal, overcurrent : status outputs
module plant_sensor_frontend #(
  parameter int unsigned ADC_W           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TEMP_HIGH       = 200,
  parameter int unsigned TEMP_LOW        = 180,
  parameter int unsigned OC_LIMIT        = 220,
  parameter int unsigned OC_CYCLES       = 3,
  parameter int unsigned SERVO_TIMEOUT   = 64,
  parameter int unsigned READY_TIME      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 metal_raw,
  input  logic                 estop_raw,
  input  logic [ADC_W-1:0]     temp_sample,
  input  logic                 temp_valid,
  input  logic [ADC_W-1:0]     current_sample,
  input  logic                 current_valid,
  plant_sensor_frontend_if.slave act,
  input  logic                 fault_clear,
  output logic                 metal_detected,
  output logic                 emergency,
  output logic                 high_temp,
  output logic                 temp_normal,
  output logic                 overcurrent
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned OC_W  = $clog2(OC_CYCLES + 1);
  localparam int unsigned TMR_W = $clog2(SERVO_TIMEOUT + 1);
  localparam int unsigned RDY_W = $clog2(READY_TIME + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MOVING = 2'd1,
    S_DONE   = 2'd2,
    S_FAULT  = 2'd3
  } servo_state_e;

  // Channel 0 = metal sensor, channel 1 = estop button.
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            db_q, db_d;
  logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;

  logic                  emergency_d;

  logic [OC_W-1:0]       oc_cnt_q, oc_cnt_d;
  logic                  overcurrent_d;

  servo_state_e          state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic [RDY_W-1:0]      rdy_cnt_q, rdy_cnt_d;
  logic                  ready_q, ready_d;

  assign metal_detected = db_q[0];
  assign act.done       = done_q;
  assign act.error      = error_q;
  assign act.ready      = ready_q;

  // Debounce: count cycles the synchronized level disagrees with the output.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Emergency uses the debouncer's next value so it tracks with no extra cycle.
  always_comb begin
    emergency_d = emergency;
`ifdef ESTOP_LATCH_EN
    if (db_d[1]) begin
      emergency_d = 1'b1;
    end else if (fault_clear && !db_q[1]) begin
      emergency_d = 1'b0;
    end
`else
    emergency_d = db_d[1];
`endif
  end

  // Overcurrent run counter; fault_clear takes priority over a trip.
  always_comb begin
    oc_cnt_d      = oc_cnt_q;
    overcurrent_d = overcurrent;
    if (fault_clear) begin
      oc_cnt_d      = '0;
      overcurrent_d = 1'b0;
    end else if (current_valid) begin
      if (current_sample > ADC_W'(OC_LIMIT)) begin
        if (oc_cnt_q != OC_W'(OC_CYCLES)) begin
          oc_cnt_d = oc_cnt_q + OC_W'(1);
          if (oc_cnt_q == OC_W'(OC_CYCLES - 1)) begin
            overcurrent_d = 1'b1;
          end
        end
      end else begin
        oc_cnt_d = '0;
      end
    end
  end

  // Servo responder next-state; done/error are registered from the next state.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (act.servo) begin
          state_d = S_MOVING;
        end
      end
      S_MOVING: begin
        timer_d = timer_q + TMR_W'(1);
        if (!act.servo) begin
          state_d = S_IDLE;
        end else if (act.servo_ack) begin
          state_d = S_DONE;
        end else if (timer_q == TMR_W'(SERVO_TIMEOUT - 1)) begin
          state_d = S_FAULT;
        end
      end
      S_DONE, S_FAULT: begin
        if (!act.servo) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_FAULT);
  end

  // Conveyor settle counter, saturating at READY_TIME.
  always_comb begin
    rdy_cnt_d = '0;
    ready_d   = 1'b0;
    if (act.conveyor && !act.servo) begin
      rdy_cnt_d = rdy_cnt_q;
      ready_d   = ready_q;
      if (rdy_cnt_q != RDY_W'(READY_TIME)) begin
        rdy_cnt_d = rdy_cnt_q + RDY_W'(1);
        if (rdy_cnt_q == RDY_W'(READY_TIME - 1)) begin
          ready_d = 1'b1;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_q        <= '0;
      db_cnt_q    <= '0;
      emergency   <= 1'b0;
      oc_cnt_q    <= '0;
      overcurrent <= 1'b0;
      state_q     <= S_IDLE;
      timer_q     <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      rdy_cnt_q   <= '0;
      ready_q     <= 1'b0;
    end else begin
      sync1_q     <= {estop_raw, metal_raw};
      sync2_q     <= sync1_q;
      db_q        <= db_d;
      db_cnt_q    <= db_cnt_d;
      emergency   <= emergency_d;
      oc_cnt_q    <= oc_cnt_d;
      overcurrent <= overcurrent_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      done_q      <= done_d;
      error_q     <= error_d;
      rdy_cnt_q   <= rdy_cnt_d;
      ready_q     <= ready_d;
    end
  end

  // Temperature hysteresis band; holds between thresholds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_temp   <= 1'b0;
      temp_normal <= 1'b1;
    end else if (temp_valid) begin
      if (temp_sample >= ADC_W'(TEMP_HIGH)) begin
        high_temp   <= 1'b1;
        temp_normal <= 1'b0;
      end else if (temp_sample <= ADC_W'(TEMP_LOW)) begin
        high_temp   <= 1'b0;
        temp_normal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_plant_sensor_frontend.sv
// Directed bench for plant_sensor_frontend with hand-computed expectations.
// Honours ESTOP_LATCH_EN to pick the expected emergency behaviour.
module tb_plant_sensor_frontend;

  logic       clk;
  logic       rst;
  logic       metal_raw;
  logic       estop_raw;
  logic [7:0] temp_sample;
  logic       temp_valid;
  logic [7:0] current_sample;
  logic       current_valid;
  logic       fault_clear;
  logic       metal_detected;
  logic       emergency;
  logic       high_temp;
  logic       temp_normal;
  logic       overcurrent;

  int n_tests = 0;
  int n_fail  = 0;

  plant_sensor_frontend_if act_if ();

  plant_sensor_frontend dut (
    .clk            (clk),
    .rst            (rst),
    .metal_raw      (metal_raw),
    .estop_raw      (estop_raw),
    .temp_sample    (temp_sample),
    .temp_valid     (temp_valid),
    .current_sample (current_sample),
    .current_valid  (current_valid),
    .act            (act_if),
    .fault_clear    (fault_clear),
    .metal_detected (metal_detected),
    .emergency      (emergency),
    .high_temp      (high_temp),
    .temp_normal    (temp_normal),
    .overcurrent    (overcurrent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [7:0] temp_vec [5] = '{8'd150, 8'd190, 8'd200, 8'd190, 8'd180};
  logic       hi_exp   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [7:0] cur_vec  [6] = '{8'd230, 8'd230, 8'd100, 8'd230, 8'd230, 8'd230};
  logic       oc_exp   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst = 1'b1;
    metal_raw = 1'b0; estop_raw = 1'b0;
    temp_sample = '0; temp_valid = 1'b0;
    current_sample = '0; current_valid = 1'b0;
    fault_clear = 1'b0;
    act_if.servo = 1'b0; act_if.conveyor = 1'b0; act_if.servo_ack = 1'b0;
    ticks(2);
    rst = 1'b0;
    ticks(10);

    // Reset / idle state
    check("idle_metal",   metal_detected, 0);
    check("idle_emerg",   emergency, 0);
    check("idle_high",    high_temp, 0);
    check("idle_normal",  temp_normal, 1);
    check("idle_oc",      overcurrent, 0);
    check("idle_done",    act_if.done, 0);
    check("idle_error",   act_if.error, 0);
    check("idle_ready",   act_if.ready, 0);

    // Metal glitch of 3 cycles must not pass
    metal_raw = 1'b1;
    ticks(3);
    metal_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("glitch_metal", metal_detected, 0);
    end

    // Held 1: rises on the 6th edge after first sample
    metal_raw = 1'b1;
    ticks(5);
    check("metal_rise_e5", metal_detected, 0);
    tick();
    check("metal_rise_e6", metal_detected, 1);
    ticks(4);
    metal_raw = 1'b0;
    ticks(5);
    check("metal_fall_e5", metal_detected, 1);
    tick();
    check("metal_fall_e6", metal_detected, 0);

    // Temperature hysteresis
    for (int i = 0; i < 5; i++) begin
      temp_sample = temp_vec[i];
      temp_valid  = 1'b1;
      tick();
      temp_valid  = 1'b0;
      check($sformatf("temp_high_%0d", i), high_temp, 32'(hi_exp[i]));
      check($sformatf("temp_norm_%0d", i), temp_normal, 32'(!hi_exp[i]));
      temp_sample = 8'd255;
      tick();
      check($sformatf("temp_hold_%0d", i), high_temp, 32'(hi_exp[i]));
    end

    // Overcurrent with idle gaps (gap samples carry over-limit values but are not valid)
    for (int i = 0; i < 6; i++) begin
      current_sample = cur_vec[i];
      current_valid  = 1'b1;
      tick();
      current_valid  = 1'b0;
      current_sample = 8'd250;
      ticks(2);
      check($sformatf("oc_after_%0d", i), overcurrent, 32'(oc_exp[i]));
    end
    ticks(5);
    check("oc_sticky", overcurrent, 1);
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    check("oc_cleared", overcurrent, 0);

    // fault_clear wins over a simultaneous trip, and clears the run counter
    current_sample = 8'd230;
    current_valid  = 1'b1;
    ticks(2);
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    check("oc_clear_wins", overcurrent, 0);
    tick();
    current_valid = 1'b0;
    check("oc_cnt_cleared", overcurrent, 0);
    current_sample = 8'd220;
    current_valid  = 1'b1;
    ticks(3);
    current_valid  = 1'b0;
    check("oc_at_limit", overcurrent, 0);

    // Servo move acknowledged after 10 cycles
    act_if.servo = 1'b1;
    ticks(10);
    check("servo_wait_done", act_if.done, 0);
    act_if.servo_ack = 1'b1;
    tick();
    act_if.servo_ack = 1'b0;
    check("servo_done", act_if.done, 1);
    check("servo_done_noerr", act_if.error, 0);
    ticks(3);
    check("servo_done_held", act_if.done, 1);
    act_if.servo = 1'b0;
    tick();
    check("servo_done_drop", act_if.done, 0);

    // Conveyor settle
    act_if.conveyor = 1'b1;
    ticks(7);
    check("ready_e7", act_if.ready, 0);
    tick();
    check("ready_e8", act_if.ready, 1);
    ticks(3);
    check("ready_held", act_if.ready, 1);

    // Servo timeout: error on the 64th edge after entering MOVING
    act_if.servo = 1'b1;
    tick();
    check("ready_cleared_by_servo", act_if.ready, 0);
    ticks(63);
    check("timeout_e63", act_if.error, 0);
    tick();
    check("timeout_e64", act_if.error, 1);
    check("timeout_nodone", act_if.done, 0);
    act_if.servo = 1'b0;
    tick();
    check("timeout_drop", act_if.error, 0);

    // Ack coinciding with the last timer value wins
    act_if.servo = 1'b1;
    ticks(64);
    act_if.servo_ack = 1'b1;
    tick();
    act_if.servo_ack = 1'b0;
    check("ack_at_limit_done", act_if.done, 1);
    check("ack_at_limit_err", act_if.error, 0);
    act_if.servo = 1'b0;
    tick();

    // Aborted move yields no done
    act_if.servo = 1'b1;
    ticks(3);
    act_if.servo = 1'b0;
    tick();
    act_if.servo_ack = 1'b1;
    tick();
    act_if.servo_ack = 1'b0;
    check("abort_nodone", act_if.done, 0);

    // Reset mid-move clears done/ready
    act_if.servo = 1'b1;
    ticks(2);
    act_if.servo_ack = 1'b1;
    tick();
    act_if.servo_ack = 1'b0;
    check("pre_rst_done", act_if.done, 1);
    rst = 1'b1;
    act_if.servo = 1'b0;
    tick();
    check("rst_done",  act_if.done, 0);
    check("rst_error", act_if.error, 0);
    check("rst_ready", act_if.ready, 0);
    rst = 1'b0;
    act_if.conveyor = 1'b0;
    tick();

    // Emergency stop
    estop_raw = 1'b1;
    ticks(6);
    check("estop_rise", emergency, 1);
    ticks(1);
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    check("estop_clear_pressed", emergency, 1);
    ticks(2);
    estop_raw = 1'b0;
    ticks(5);
    check("estop_release_e5", emergency, 1);
    tick();
`ifdef ESTOP_LATCH_EN
    check("estop_latched_e6", emergency, 1);
    ticks(4);
    check("estop_latched_hold", emergency, 1);
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    check("estop_cleared", emergency, 0);
`else
    check("estop_release_e6", emergency, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/plant_sensor_frontend.md
Name: plant_sensor_frontend

Overview:
- Conditions raw plant sensors and actuator feedback into the clean status/event signals consumed by the line-control FSM: metal_detected, high_temp, temp_normal, overcurrent, done, error, ready, emergency.
- Acts as the responder end of the FSM's actuator interface. It receives the servo and conveyor commands and returns done, error and ready after supervised timing.
- Sits between the sensor/ADC pins and the control FSM.

Parameters:
ADC_W, 8, width of temperature and current samples
DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a debounced output changes (>=1)
TEMP_HIGH, 200, temperature sample >= this sets high_temp
TEMP_LOW, 180, temperature sample <= this sets temp_normal (must be < TEMP_HIGH)
OC_LIMIT, 220, current sample > this counts as over-limit
OC_CYCLES, 3, consecutive over-limit valid samples required to trip overcurrent
SERVO_TIMEOUT, 64, cycles in MOVING before error
READY_TIME, 8, cycles of conveyor=1 with servo=0 before ready asserts

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
metal_raw  in  1  raw metal sensor, asynchronous
estop_raw  in  1  raw emergency button, asynchronous
temp_sample  in  ADC_W  temperature ADC result
temp_valid  in  1  temp_sample valid this cycle
current_sample  in  ADC_W  motor current ADC result
current_valid  in  1  current_sample valid this cycle
servo  in  1  servo command from control FSM
conveyor  in  1  conveyor command from control FSM
servo_ack  in  1  servo end-position switch, synchronous
fault_clear  in  1  clears sticky faults (wired to reset_btn)
metal_detected  out  1  debounced metal sensor
emergency  out  1  debounced estop
high_temp  out  1  temperature above band
temp_normal  out  1  temperature below band
overcurrent  out  1  sticky overcurrent fault
done  out  1  servo move complete
error  out  1  servo move timeout
ready  out  1  conveyor settled after servo cycle

Behaviour:
- All outputs are registered. Reset values: metal_detected=0, emergency=0, high_temp=0, temp_normal=1, overcurrent=0, done=0, error=0, ready=0. All counters reset to 0 and the servo FSM resets to S_IDLE.
- A reset asserted mid-operation aborts any move or count immediately.

Debounce (metal_raw, estop_raw):
- Each input passes through a 2-flop synchronizer, then a counter.
- Counter increments while the synchronized value differs from the output and clears when it matches.
- The output takes the new value on the edge where the counter reaches DEBOUNCE_CYCLES. Latency is exactly DEBOUNCE_CYCLES+2 edges after the first edge sampling a stable new level.
- A glitch shorter than DEBOUNCE_CYCLES produces no output change.

Temperature hysteresis (updates only on edges with temp_valid=1; outputs visible 1 cycle later):
- sample >= TEMP_HIGH: high_temp=1, temp_normal=0.
- sample <= TEMP_LOW: high_temp=0, temp_normal=1.
- In between: both hold.
- The two outputs are never 1 simultaneously.

Overcurrent:
- On current_valid: sample > OC_LIMIT increments the run counter, saturating at OC_CYCLES; otherwise the counter clears.
- Cycles with current_valid=0 leave the counter unchanged.
- overcurrent sets on the edge where the counter reaches OC_CYCLES and is sticky.
- fault_clear clears overcurrent and the counter. If fault_clear and a trip occur in the same cycle, fault_clear wins.

Servo responder FSM (timer is 0 on entry to MOVING):
- S_IDLE: servo=1 -> S_MOVING.
- S_MOVING: timer increments each cycle.
  - servo=0 -> S_IDLE (aborted, no done).
  - else servo_ack=1 -> S_DONE. If servo_ack and timer==SERVO_TIMEOUT-1 coincide, ack wins.
  - else timer==SERVO_TIMEOUT-1 -> S_FAULT.
- S_DONE: done=1; servo=0 -> S_IDLE.
- S_FAULT: error=1; servo=0 -> S_IDLE.
- done and error are levels, held until servo drops, and are mutually exclusive.

Ready:
- Settle counter runs while conveyor=1 and servo=0. It clears, and ready clears, whenever conveyor=0 or servo=1.
- ready=1 on the edge the counter reaches READY_TIME. The counter saturates there.

Optional Feature:
ESTOP_LATCH_EN
- Defined: emergency is sticky once the debounced estop asserts. It clears only on fault_clear while the debounced estop is 0; if estop is still asserted, fault_clear is ignored.
- Undefined: emergency directly follows the debounced estop level, and fault_clear has no effect on it.

Test Plan:
- Reset, then idle 10 cycles -> temp_normal=1, all other outputs 0. Assert rst mid-move -> done, error and ready are 0 on the next edge.
- metal_raw pulse of 3 cycles, then a 1 held 10 cycles, DEBOUNCE_CYCLES=4 -> no output change for the pulse; metal_detected=1 exactly 6 edges after the held 1 is first sampled; symmetric fall.
- Temperature samples 150, 190, 200, 190, 180 -> high_temp 0,0,1,1,0 and temp_normal 1,1,0,0,1, each 1 cycle after its valid.
- Current samples 230, 230, 100, 230, 230, 230, with idle gaps between valids -> overcurrent=1 only after the 6th sample; stays 1 until fault_clear; cleared the cycle after fault_clear.
- servo=1, servo_ack at cycle 10 -> done=1, held until servo=0. Then conveyor=1, servo=0 -> ready=1 after 8 cycles. servo=1 with no ack -> error=1 after 64 cycles.
- estop_raw held 10 cycles, then released; fault_clear pulsed while still pressed, then after release -> with ESTOP_LATCH_EN, emergency stays 1 until the post-release clear; without it, emergency falls 6 edges after release.
